// File: rtl/mc_window_counter_if.sv
// mc_window_counter_if: serial readout and status bundle driven by mc_window_counter.
// The master side is the counter and the slave side is the frame consumer.
interface mc_window_counter_if #(
    parameter int AW = 3
);
    logic          serial_out;
    logic          ser_valid;
    logic [AW-1:0] addr;
    logic          ovf_ch;
    logic          ovf_global;
    logic          ovf_rtc;
    logic          busy;

    modport master (
        output serial_out, ser_valid, addr, ovf_ch, ovf_global, ovf_rtc, busy
    );

    modport slave (
        input serial_out, ser_valid, addr, ovf_ch, ovf_global, ovf_rtc, busy
    );
endinterface

// File: rtl/mc_window_counter.sv
// mc_window_counter: multi-channel event counter, RTC-closed windows, serial snapshot readout.
// Define MC_WINDOW_COUNTER_PARITY_EN to append an even-parity bit after each channel word.
//
// state | meaning
// IDLE  | counting only; waits for an rtc edge to snapshot the window
// SHIFT | snapshot being shifted out, channel 0 first, MSB first
module mc_window_counter #(
    parameter int NUM_CH   = 8,
    parameter int CNT_W    = 16,
    parameter int SATURATE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    ch,
    input  logic                 rtc,
    mc_window_counter_if.master  bus
);
    localparam int AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef MC_WINDOW_COUNTER_PARITY_EN
    localparam int WORD_LEN = CNT_W + 1;
`else
    localparam int WORD_LEN = CNT_W;
`endif
    localparam int BW = $clog2(WORD_LEN);
    localparam int SW = $clog2(CNT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t state, state_nxt;

    logic [NUM_CH-1:0] ch_s1, ch_s2, ch_s3;
    logic              rtc_s1, rtc_s2, rtc_s3;
    logic [NUM_CH-1:0] ch_ev;
    logic              rtc_ev;

    logic [CNT_W-1:0]  cnt    [NUM_CH];
    logic [NUM_CH-1:0] ovf;
    logic [CNT_W-1:0]  sh_cnt [NUM_CH];
    logic [NUM_CH-1:0] sh_ovf;
    logic              ovf_global_q;
    logic              ovf_rtc_q;

    logic [AW-1:0]     ch_idx;
    logic [BW-1:0]     bit_idx;
    logic              snap;
    logic              last_bit;

    logic [CNT_W-1:0]  cur_word;
    logic [SW-1:0]     bit_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_s1  <= '0;
            ch_s2  <= '0;
            ch_s3  <= '0;
            rtc_s1 <= 1'b0;
            rtc_s2 <= 1'b0;
            rtc_s3 <= 1'b0;
        end else begin
            ch_s1  <= ch;
            ch_s2  <= ch_s1;
            ch_s3  <= ch_s2;
            rtc_s1 <= rtc;
            rtc_s2 <= rtc_s1;
            rtc_s3 <= rtc_s2;
        end
    end

    assign ch_ev    = ch_s2 & ~ch_s3;
    assign rtc_ev   = rtc_s2 & ~rtc_s3;
    assign snap     = (state == IDLE) && rtc_ev;
    assign last_bit = (state == SHIFT) && (ch_idx == AW'(NUM_CH - 1))
                      && (bit_idx == BW'(WORD_LEN - 1));

    // A channel event landing in the snapshot cycle belongs to the new window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (snap) begin
                    cnt[i] <= ch_ev[i] ? CNT_ONE : '0;
                    ovf[i] <= 1'b0;
                end else if (ch_ev[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        ovf[i] <= 1'b1;
                        cnt[i] <= (SATURATE != 0) ? CNT_MAX : '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sh_cnt[i] <= '0;
            end
            sh_ovf       <= '0;
            ovf_global_q <= 1'b0;
            ovf_rtc_q    <= 1'b0;
        end else if (snap) begin
            sh_cnt       <= cnt;
            sh_ovf       <= ovf;
            ovf_global_q <= |ovf;
            ovf_rtc_q    <= 1'b0;
        end else if ((state == SHIFT) && rtc_ev) begin
            ovf_rtc_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_idx  <= '0;
            bit_idx <= '0;
        end else if (snap || last_bit) begin
            ch_idx  <= '0;
            bit_idx <= '0;
        end else if (state == SHIFT) begin
            if (bit_idx == BW'(WORD_LEN - 1)) begin
                bit_idx <= '0;
                ch_idx  <= ch_idx + 1'b1;
            end else begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rtc_ev)   state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.serial_out = 1'b0;
        bus.ser_valid  = 1'b0;
        bus.addr       = '0;
        bus.ovf_ch     = 1'b0;
        bus.busy       = 1'b0;
        bus.ovf_global = ovf_global_q;
        bus.ovf_rtc    = ovf_rtc_q;
        cur_word       = sh_cnt[ch_idx];
        bit_sel        = SW'(CNT_W - 1) - SW'(bit_idx);
        if (state == SHIFT) begin
            bus.ser_valid = 1'b1;
            bus.busy      = 1'b1;
            bus.addr      = ch_idx;
            bus.ovf_ch    = sh_ovf[ch_idx];
`ifdef MC_WINDOW_COUNTER_PARITY_EN
            if (bit_idx == BW'(CNT_W)) begin
                bus.serial_out = ^cur_word;
            end else begin
                bus.serial_out = cur_word[bit_sel];
            end
`else
            bus.serial_out = cur_word[bit_sel];
`endif
        end
    end
endmodule

// File: tb/tb_mc_window_counter.sv
// Bench for mc_window_counter: three parameter sets share one stimulus; an event-level
// model predicts every output each cycle, and literal frame contents pin that model.
module tb_mc_window_counter;
    localparam int NCFG = 3;
    localparam int NCH  = 8;
`ifdef MC_WINDOW_COUNTER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    function automatic int cfg_w(input int k);
        return (k == 0) ? 16 : 4;
    endfunction
    function automatic int cfg_sat(input int k);
        return (k == 2) ? 1 : 0;
    endfunction
    function automatic int frame_len(input int k);
        return NCH * (cfg_w(k) + PAR);
    endfunction

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [NCH-1:0] ch = '0;
    logic           rtc = 1'b0;
    always #5 clk = ~clk;

    mc_window_counter_if #(.AW(3)) bus0 ();
    mc_window_counter_if #(.AW(3)) bus1 ();
    mc_window_counter_if #(.AW(3)) bus2 ();

    mc_window_counter #(.NUM_CH(8), .CNT_W(16), .SATURATE(0)) dut0 (
        .clk(clk), .reset(reset), .ch(ch), .rtc(rtc), .bus(bus0));
    mc_window_counter #(.NUM_CH(8), .CNT_W(4), .SATURATE(0)) dut1 (
        .clk(clk), .reset(reset), .ch(ch), .rtc(rtc), .bus(bus1));
    mc_window_counter #(.NUM_CH(8), .CNT_W(4), .SATURATE(1)) dut2 (
        .clk(clk), .reset(reset), .ch(ch), .rtc(rtc), .bus(bus2));

    // {serial_out, ser_valid, addr[2:0], ovf_ch, ovf_global, ovf_rtc, busy}
    logic [8:0] obs0, obs1, obs2;
    assign obs0 = {bus0.serial_out, bus0.ser_valid, bus0.addr, bus0.ovf_ch,
                   bus0.ovf_global, bus0.ovf_rtc, bus0.busy};
    assign obs1 = {bus1.serial_out, bus1.ser_valid, bus1.addr, bus1.ovf_ch,
                   bus1.ovf_global, bus1.ovf_rtc, bus1.busy};
    assign obs2 = {bus2.serial_out, bus2.ser_valid, bus2.addr, bus2.ovf_ch,
                   bus2.ovf_global, bus2.ovf_rtc, bus2.busy};

    function automatic logic [8:0] get_obs(input int k);
        return (k == 0) ? obs0 : ((k == 1) ? obs1 : obs2);
    endfunction

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit run = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: every channel event and rtc edge tagged with the clock edge at which it acts.
    int ev_ch [$];
    int ev_act [$];
    int rtc_act [$];
    int ws [NCFG];
    int fstart [NCFG];
    int fend [NCFG];
    int shv [NCFG][NCH];
    bit sho [NCFG][NCH];
    bit m_og [NCFG];
    bit m_orc [NCFG];

    int cap_word [NCFG][NCH];
    int cap_par [NCFG][NCH];
    int cap_cnt [NCFG][NCH];
    int cap_len [NCFG];
    bit pv [NCFG];
    logic [8:0] co;

    function automatic void model_reset();
        ev_ch.delete();
        ev_act.delete();
        rtc_act.delete();
        for (int k = 0; k < NCFG; k++) begin
            ws[k] = 0;
            fstart[k] = -1000;
            fend[k] = -1000;
            m_og[k] = 1'b0;
            m_orc[k] = 1'b0;
        end
    endfunction

    function automatic void model_rtc(input int k, input int s);
        int n, full, mx;
        if (s > fend[k]) begin
            full = 1 << cfg_w(k);
            mx = full - 1;
            m_og[k] = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                n = 0;
                for (int e = 0; e < ev_ch.size(); e++)
                    if (ev_ch[e] == c && ev_act[e] >= ws[k] && ev_act[e] < s) n++;
                sho[k][c] = (n >= full);
                shv[k][c] = (cfg_sat(k) != 0) ? ((n > mx) ? mx : n) : (n % full);
                m_og[k] = m_og[k] | sho[k][c];
            end
            m_orc[k] = 1'b0;
            ws[k] = s;
            fstart[k] = s;
            fend[k] = s + frame_len(k);
        end else begin
            m_orc[k] = 1'b1;
        end
    endfunction

    function automatic logic [8:0] model_out(input int k, input int t);
        logic [8:0] e;
        int idx, c, b, w;
        e = '0;
        e[2] = m_og[k];
        e[1] = m_orc[k];
        w = cfg_w(k);
        if (t >= fstart[k] && t < fend[k]) begin
            idx = t - fstart[k];
            c = idx / (w + PAR);
            b = idx % (w + PAR);
            if (b < w) e[8] = ((shv[k][c] >> (w - 1 - b)) & 1) != 0;
            else       e[8] = ($countones(shv[k][c]) % 2) != 0;
            e[7] = 1'b1;
            e[6:4] = c[2:0];
            e[3] = sho[k][c];
            e[0] = 1'b1;
        end
        return e;
    endfunction

    task automatic cmp(input int k, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL outputs dut%0d cyc=%0d got=%b exp=%b (so,sv,addr3,ovf_ch,ovf_g,ovf_rtc,busy)",
                     k, cyc, got, exp);
        end
    endtask

    task automatic lit(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            if (reset) begin
                for (int k = 0; k < NCFG; k++) cmp(k, get_obs(k), 9'd0);
            end else begin
                while (rtc_act.size() > 0 && rtc_act[0] <= cyc) begin
                    if (rtc_act[0] == cyc)
                        for (int k = 0; k < NCFG; k++) model_rtc(k, cyc);
                    void'(rtc_act.pop_front());
                end
                for (int k = 0; k < NCFG; k++) cmp(k, get_obs(k), model_out(k, cyc));
            end
            for (int k = 0; k < NCFG; k++) begin
                co = get_obs(k);
                if (co[7]) begin
                    if (!pv[k]) begin
                        cap_len[k] = 0;
                        for (int c = 0; c < NCH; c++) begin
                            cap_word[k][c] = 0;
                            cap_par[k][c] = 0;
                            cap_cnt[k][c] = 0;
                        end
                    end
                    cap_len[k]++;
                    if (cap_cnt[k][int'(co[6:4])] < cfg_w(k))
                        cap_word[k][int'(co[6:4])] = (cap_word[k][int'(co[6:4])] << 1) | int'(co[8]);
                    else
                        cap_par[k][int'(co[6:4])] = int'(co[8]);
                    cap_cnt[k][int'(co[6:4])]++;
                end
                pv[k] = co[7];
            end
        end
    end

    task automatic pulse(input logic [NCH-1:0] m, input bit with_rtc);
        @(posedge clk);
        #1;
        ch = m;
        rtc = with_rtc;
        for (int i = 0; i < NCH; i++)
            if (m[i]) begin
                ev_ch.push_back(i);
                ev_act.push_back(cyc + 3);
            end
        if (with_rtc) rtc_act.push_back(cyc + 3);
        repeat (3) @(posedge clk);
        #1;
        ch = '0;
        rtc = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_busy();
        int n;
        n = 0;
        while (!bus0.busy && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        lit("busy_rise_timeout", int'(bus0.busy), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus0.busy && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        lit("busy_fall_timeout", int'(bus0.busy), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        #2;
        reset = 1'b1;
        run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        lit("reset_outputs", int'(obs0), 0);
        #1;
        reset = 1'b0;

        // Window 1: ch0 x5, ch7 x3.
        for (int i = 0; i < 5; i++) pulse((i < 3) ? 8'h81 : 8'h01, 1'b0);
        pulse(8'h00, 1'b1);
        wait_busy();
        wait_idle();
        lit("w1_frame_len", cap_len[0], (PAR != 0) ? 136 : 128);
        lit("w1_d0_ch0", cap_word[0][0], 5);
        lit("w1_d0_ch7", cap_word[0][7], 3);
        lit("w1_d0_ch2", cap_word[0][2], 0);
        lit("w1_d1_ch0", cap_word[1][0], 5);
        lit("w1_d0_ovf_global", int'(obs0[2]), 0);
`ifdef MC_WINDOW_COUNTER_PARITY_EN
        lit("w1_d0_ch0_parity", cap_par[0][0], 0);
`endif

        // Window 2: ch2 x18 (overflows 4-bit), ch1 x7; rtc dropped mid-frame.
        for (int i = 0; i < 18; i++) pulse((i < 7) ? 8'h06 : 8'h04, 1'b0);
        pulse(8'h00, 1'b1);
        wait_busy();
        pulse(8'h08, 1'b0);
        pulse(8'h00, 1'b1);
        pulse(8'h08, 1'b0);
        wait_idle();
        lit("w2_d0_ch2", cap_word[0][2], 18);
        lit("w2_d1_ch2_wrap", cap_word[1][2], 2);
        lit("w2_d2_ch2_sat", cap_word[2][2], 15);
        lit("w2_d0_ch1", cap_word[0][1], 7);
        lit("w2_d1_ovf_global", int'(obs1[2]), 1);
        lit("w2_d2_ovf_global", int'(obs2[2]), 1);
        lit("w2_d0_ovf_global", int'(obs0[2]), 0);
        lit("w2_d0_ovf_rtc", int'(obs0[1]), 1);
        lit("w2_d1_ovf_rtc", int'(obs1[1]), 1);
`ifdef MC_WINDOW_COUNTER_PARITY_EN
        lit("w2_d0_ch1_parity", cap_par[0][1], 1);
`endif

        // Window 3: ch1 coincides with the snapshot; extended window carries ch3 x2.
        pulse(8'h02, 1'b1);
        wait_busy();
        wait_idle();
        lit("w3_d0_ch1_coincident", cap_word[0][1], 0);
        lit("w3_d0_ch3_extended", cap_word[0][3], 2);
        lit("w3_d0_ovf_rtc_cleared", int'(obs0[1]), 0);
        lit("w3_d1_ovf_global", int'(obs1[2]), 0);

        pulse(8'h00, 1'b1);
        wait_busy();
        wait_idle();
        lit("w4_d0_ch1_carried", cap_word[0][1], 1);

        // Reset mid-frame, then an empty window.
        pulse(8'h20, 1'b0);
        pulse(8'h00, 1'b1);
        wait_busy();
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        lit("midreset_d0", int'(obs0), 0);
        lit("midreset_d1", int'(obs1), 0);
        lit("midreset_d2", int'(obs2), 0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        pulse(8'h00, 1'b1);
        wait_busy();
        wait_idle();
        for (int c = 0; c < NCH; c++) lit("postreset_d0_word", cap_word[0][c], 0);
        lit("postreset_frame_len", cap_len[0], (PAR != 0) ? 136 : 128);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
